alu_program_sequencer: RTL and testbench
========================================

// Module: alu_program_sequencer
// PURPOSE
//   Multi-cycle controller that sits directly upstream of the register-file + ALU datapath top.
//   It holds a small loadable program memory and fetches/decodes one instruction at a time.
//   It drives opcode/A1/A2/A3/WD3/WE3 into the datapath and captures the datapath's 32-bit
//   result for write-back. Runs from a start pulse until a HALT instruction, then reports done.
// PARAMETERS
//   IMEM_DEPTH  32  program memory entries (power of 2, >=2)
//   PC_W        5   program counter width, = $clog2(IMEM_DEPTH)
//   CNT_W       16  width of retired-instruction counter
// PORTS
//   CLK          in   1      rising-edge clock
//   RST          in   1      synchronous, active-high reset
//   prog_we      in   1      program-memory write strobe (accepted only in IDLE/DONE)
//   prog_addr    in   PC_W   program-memory write address
//   prog_data    in   24     instruction word to store
//   start        in   1      1-cycle pulse: begin execution at PC=0 (only from IDLE/DONE)
//   result       in   32     ALU result from datapath (combinational from A1/A2/opcode)
//   opcode       out  2      ALU operation to datapath
//   A1, A2       out  5      register-file read addresses
//   A3           out  5      register-file write address
//   WD3          out  32     register-file write data
//   WE3          out  1      register-file write enable
//   busy         out  1      high in FETCH/EXEC/WB
//   done         out  1      high in DONE state (level, until next start or RST)
//   pc           out  PC_W   current program counter
//   retired      out  CNT_W  instructions retired since last start (saturating)
// BEHAVIOUR
//   Instruction [23:22] class: 00 ALU, 01 LOADI, 10 HALT, 11 NOP.
//     ALU:   [21:20] op, [19:15] rd, [14:10] rs1, [9:5] rs2, [4:0] ignored
//     LOADI: [19:15] rd, [14:0] imm, zero-extended to 32 bits; [21:20] ignored
//   Program memory is synchronous: a write lands on the edge; a read is registered in FETCH.
//   FSM states: IDLE, FETCH, EXEC, WB, DONE.
//     IDLE  : start -> FETCH with pc=0, retired=0.
//     FETCH : ir <= imem[pc]; -> EXEC.
//     EXEC  : ALU drives A1=rs1, A2=rs2, opcode=op; res_q <= result; -> WB.
//             LOADI sets res_q <= imm; -> WB.
//             NOP -> FETCH, pc+1, retired+1.
//             HALT -> DONE; pc is not incremented; not counted as retired.
//     WB    : WE3=1, A3=rd, WD3=res_q for exactly one cycle; pc+1, retired+1; -> FETCH.
//     DONE  : start -> FETCH with pc=0, retired=0.
//   Latency: ALU/LOADI = 3 cycles per instruction, NOP = 2 cycles, HALT = 2 cycles to done.
//   A1/A2/opcode hold their EXEC values through WB. WE3 is 0 in every state except WB.
//   rd=0 is written like any other register (no special case).
//   pc wraps IMEM_DEPTH-1 -> 0 with no flag. retired saturates at 2^CNT_W-1.
//   start while busy: ignored. prog_we while busy: ignored; memory unchanged.
//   prog_we and start in the same cycle from IDLE: the write lands and execution starts.
//     The FETCH that follows sees the new word.
//   RST (any state, including mid-WB): next edge -> IDLE; pc=0, retired=0.
//     WE3, busy and done go to 0. opcode, A1, A2, A3 and WD3 go to 0.
//     Program memory contents are preserved.
// TESTING
//   1. Load LOADI r1,5; LOADI r2,7; ALU op0 r3,r1,r2; HALT; start.
//      -> WE3 pulses at A3=1 (WD3=5), then A3=2 (WD3=7), then A3=3 (WD3=result).
//      -> done on cycle 11 after start; retired=3.
//   2. NOP at pc0 and HALT at pc1 -> no WE3 pulse; done 4 cycles after start; retired=1.
//   3. Pulse start and prog_we mid-run -> both ignored: pc sequence and memory read-back unchanged.
//   4. Assert RST during WB of an ALU instruction.
//      -> next cycle WE3=0, busy=0, pc=0.
//      -> a restart re-executes the program identically.
//   5. Fill all 32 entries with NOP -> pc wraps 31->0 and execution continues.
//      -> retired keeps counting past 32; busy remains 1.
//   6. Start from DONE -> retired clears to 0; pc=0; program re-runs.

Source files
------------

// File: rtl/alu_program_sequencer.sv
// Multi-cycle fetch/decode/execute controller that feeds a register-file + ALU datapath.
// Holds a loadable program memory and runs from a start pulse until a HALT instruction.
module alu_program_sequencer #(
    parameter int IMEM_DEPTH = 32,
    parameter int PC_W       = $clog2(IMEM_DEPTH),
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             prog_we,
    input  logic [PC_W-1:0]  prog_addr,
    input  logic [23:0]      prog_data,
    input  logic             start,
    input  logic [31:0]      result,
    output logic [1:0]       opcode,
    output logic [4:0]       A1,
    output logic [4:0]       A2,
    output logic [4:0]       A3,
    output logic [31:0]      WD3,
    output logic             WE3,
    output logic             busy,
    output logic             done,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [1:0] CLS_ALU   = 2'b00;
    localparam logic [1:0] CLS_LOADI = 2'b01;
    localparam logic [1:0] CLS_HALT  = 2'b10;
    localparam logic [1:0] CLS_NOP   = 2'b11;

    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] retired_nxt;

    logic [23:0]      imem [IMEM_DEPTH];
    logic [23:0]      ir_p1;
    logic [31:0]      res_p2;

    logic [1:0]       ir_cls;
    logic [1:0]       ir_op;
    logic [4:0]       ir_rd;
    logic [4:0]       ir_rs1;
    logic [4:0]       ir_rs2;
    logic [14:0]      ir_imm;
    logic             idle_like;
    logic             imem_wr;

    assign ir_cls = ir_p1[23:22];
    assign ir_op  = ir_p1[21:20];
    assign ir_rd  = ir_p1[19:15];
    assign ir_rs1 = ir_p1[14:10];
    assign ir_rs2 = ir_p1[9:5];
    assign ir_imm = ir_p1[14:0];

    // Loading and launching are only honoured while no program is running.
    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign imem_wr   = prog_we && idle_like;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            pc      <= '0;
            retired <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            retired <= retired_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (imem_wr) begin
            imem[prog_addr] <= prog_data;
        end
    end

    // Fetch stage: instruction register loads from program memory
    always_ff @(posedge CLK) begin
        if (state == S_FETCH) begin
            ir_p1 <= imem[pc];
        end
    end

    // Execute stage: capture datapath result or immediate for write-back
    always_ff @(posedge CLK) begin
        if (state == S_EXEC) begin
            res_p2 <= (ir_cls == CLS_LOADI) ? {17'b0, ir_imm} : result;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        retired_nxt = retired;
        opcode      = '0;
        A1          = '0;
        A2          = '0;
        A3          = '0;
        WD3         = '0;
        WE3         = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    state_nxt   = S_FETCH;
                    pc_nxt      = '0;
                    retired_nxt = '0;
                end
            end
            S_FETCH: begin
                busy      = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                case (ir_cls)
                    CLS_NOP: begin
                        state_nxt   = S_FETCH;
                        pc_nxt      = pc + PC_ONE;
                        retired_nxt = sat_inc(retired);
                    end
                    CLS_HALT: begin
                        state_nxt = S_DONE;
                    end
                    default: begin
                        state_nxt = S_WB;
                    end
                endcase
            end
            S_WB: begin
                busy        = 1'b1;
                WE3         = 1'b1;
                A3          = ir_rd;
                WD3         = res_p2;
                state_nxt   = S_FETCH;
                pc_nxt      = pc + PC_ONE;
                retired_nxt = sat_inc(retired);
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Operand addresses stay on the datapath from EXEC through WB.
        if (((state == S_EXEC) || (state == S_WB)) && (ir_cls == CLS_ALU)) begin
            opcode = ir_op;
            A1     = ir_rs1;
            A2     = ir_rs2;
        end
    end

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Scoreboard bench for alu_program_sequencer: an ISA-level model predicts write-backs and timing,
// a small register-file + ALU model plays the datapath, and a monitor checks every WE3 pulse.
module tb_alu_program_sequencer;

    localparam int IMEM_DEPTH = 32;
    localparam int PC_W       = 5;
    localparam int CNT_W      = 16;

    localparam logic [23:0] W_HALT = 24'h800000;
    localparam logic [23:0] W_NOP  = 24'hC00000;

    logic             CLK = 1'b0;
    logic             RST;
    logic             prog_we;
    logic [PC_W-1:0]  prog_addr;
    logic [23:0]      prog_data;
    logic             start;
    logic [31:0]      result;
    logic [1:0]       opcode;
    logic [4:0]       A1;
    logic [4:0]       A2;
    logic [4:0]       A3;
    logic [31:0]      WD3;
    logic             WE3;
    logic             busy;
    logic             done;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] retired;

    always #5 CLK = ~CLK;

    alu_program_sequencer #(
        .IMEM_DEPTH(IMEM_DEPTH),
        .PC_W      (PC_W),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .start    (start),
        .result   (result),
        .opcode   (opcode),
        .A1       (A1),
        .A2       (A2),
        .A3       (A3),
        .WD3      (WD3),
        .WE3      (WE3),
        .busy     (busy),
        .done     (done),
        .pc       (pc),
        .retired  (retired)
    );

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd3;
        bit          is_alu;
        logic [1:0]  op;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } wb_t;

    wb_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] dp_rf  [32] = '{default: '0};
    logic [31:0] ref_rf [32] = '{default: '0};
    logic [23:0] prog   [32] = '{default: '0};

    function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [23:0] f_alu(input logic [1:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {2'b00, op, rd, rs1, rs2, 5'b0};
    endfunction

    function automatic logic [23:0] f_ld(input logic [4:0] rd, input logic [14:0] imm);
        return {2'b01, 2'b00, rd, imm};
    endfunction

    // Datapath stand-in: register file written on WE3, ALU combinational from A1/A2/opcode
    always_ff @(posedge CLK) begin
        if (WE3 === 1'b1) dp_rf[A3] <= WD3;
    end
    assign result = alu_f(opcode, dp_rf[A1], dp_rf[A2]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    always @(negedge CLK) begin
        wb_t e;
        if (WE3 === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_we3: got write A3=%0d WD3=%0h, expected no write", A3, WD3);
            end else begin
                e = exp_q.pop_front();
                chk("wb_a3", A3, e.a3);
                chk("wb_wd3", WD3, e.wd3);
                if (e.is_alu) begin
                    chk("wb_opcode", opcode, e.op);
                    chk("wb_a1", A1, e.a1);
                    chk("wb_a2", A2, e.a2);
                end
            end
        end
    end

    // Instruction-level interpreter: pushes expected write-backs and returns timing/counters.
    task automatic model_run(output int cyc, output int ret, output int hpc);
        int          p;
        logic [23:0] w;
        wb_t         e;
        p   = 0;
        cyc = 0;
        ret = 0;
        hpc = -1;
        for (int s = 0; s < 64; s++) begin
            w = prog[p];
            e.is_alu = 1'b0;
            e.op = '0;
            e.a1 = '0;
            e.a2 = '0;
            e.a3 = w[19:15];
            case (w[23:22])
                2'b00: begin
                    e.is_alu = 1'b1;
                    e.op  = w[21:20];
                    e.a1  = w[14:10];
                    e.a2  = w[9:5];
                    e.wd3 = alu_f(e.op, ref_rf[e.a1], ref_rf[e.a2]);
                    ref_rf[e.a3] = e.wd3;
                    exp_q.push_back(e);
                    cyc += 3;
                    ret++;
                    p = (p + 1) % 32;
                end
                2'b01: begin
                    e.wd3 = {17'b0, w[14:0]};
                    ref_rf[e.a3] = e.wd3;
                    exp_q.push_back(e);
                    cyc += 3;
                    ret++;
                    p = (p + 1) % 32;
                end
                2'b11: begin
                    cyc += 2;
                    ret++;
                    p = (p + 1) % 32;
                end
                default: begin
                    cyc += 2;
                    hpc = p;
                    return;
                end
            endcase
        end
    endtask

    task automatic load_word(input int a, input logic [23:0] w);
        @(negedge CLK);
        prog_we   = 1'b1;
        prog_addr = a[4:0];
        prog_data = w;
        prog[a]   = w;
        @(negedge CLK);
        prog_we   = 1'b0;
    endtask

    task automatic gen_random(output int n);
        n = $urandom_range(6, 20);
        for (int i = 0; i < n; i++) begin
            int k = $urandom_range(0, 2);
            logic [23:0] w;
            w = 24'($urandom);
            case (k)
                0:       w[23:22] = 2'b00;
                1:       w[23:22] = 2'b01;
                default: w[23:22] = 2'b11;
            endcase
            load_word(i, w);
        end
        load_word(n, W_HALT);
    endtask

    // wr0: write prog[0] in the start cycle; dis_addr >= 0: pulse start + prog_we mid-run
    task automatic run_prog(input bit wr0, input int dis_addr, output int cyc);
        int ecyc, eret, epc;
        model_run(ecyc, eret, epc);
        @(negedge CLK);
        start = 1'b1;
        if (wr0) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = prog[0];
        end
        @(negedge CLK);
        start   = 1'b0;
        prog_we = 1'b0;
        chk("launch_busy", busy, 1);
        chk("launch_pc", pc, 0);
        chk("launch_retired", retired, 0);
        cyc = 0;
        while (done !== 1'b1 && cyc < ecyc + 20) begin
            if (dis_addr >= 0 && cyc == 3) begin
                start     = 1'b1;
                prog_we   = 1'b1;
                prog_addr = dis_addr[4:0];
                prog_data = W_HALT;
            end else begin
                start   = 1'b0;
                prog_we = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        start   = 1'b0;
        prog_we = 1'b0;
        chk("done_cycles", cyc, ecyc);
        chk("done_retired", retired, eret);
        chk("done_pc", pc, epc);
        chk("done_busy", busy, 0);
        chk("wb_all_seen", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int n, cyc, ecyc, eret, epc;
        RST       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_we3", WE3, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pc", pc, 0);
        chk("reset_retired", retired, 0);
        chk("reset_opcode", opcode, 0);
        chk("reset_a1", A1, 0);
        chk("reset_a2", A2, 0);
        chk("reset_a3", A3, 0);
        chk("reset_wd3", WD3, 0);
        RST = 1'b0;

        // Two loads, an add, halt
        load_word(0, f_ld(5'd1, 15'd5));
        load_word(1, f_ld(5'd2, 15'd7));
        load_word(2, f_alu(2'd0, 5'd3, 5'd1, 5'd2));
        load_word(3, W_HALT);
        run_prog(1'b0, -1, cyc);
        chk("t1_done_cycle", cyc, 11);
        chk("t1_r3", dp_rf[3], 12);
        // Restart from DONE
        run_prog(1'b0, -1, cyc);

        // NOP then HALT
        load_word(0, W_NOP);
        load_word(1, W_HALT);
        run_prog(1'b0, -1, cyc);
        chk("t2_done_cycle", cyc, 4);

        // Start and prog_we while busy are ignored; rerun proves memory unchanged
        gen_random(n);
        run_prog(1'b0, n - 1, cyc);
        run_prog(1'b0, -1, cyc);

        // Reset during WB of the ALU instruction, then restart
        load_word(0, f_ld(5'd1, 15'd5));
        load_word(1, f_ld(5'd2, 15'd7));
        load_word(2, f_alu(2'd0, 5'd3, 5'd1, 5'd2));
        load_word(3, W_HALT);
        model_run(ecyc, eret, epc);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cyc = 0;
        while (!(WE3 === 1'b1 && A3 === 5'd3) && cyc < 30) begin
            @(negedge CLK);
            cyc++;
        end
        chk("rst_wb_reached", (cyc < 30), 1);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_wb_we3", WE3, 0);
        chk("rst_wb_busy", busy, 0);
        chk("rst_wb_pc", pc, 0);
        chk("rst_wb_retired", retired, 0);
        chk("rst_wb_a3", A3, 0);
        RST = 1'b0;
        chk("rst_wb_queue", exp_q.size(), 0);
        exp_q.delete();
        run_prog(1'b0, -1, cyc);
        chk("rst_restart_cycle", cyc, 11);

        // All-NOP memory: pc wraps and execution continues
        for (int i = 0; i < 32; i++) load_word(i, W_NOP | 24'($urandom_range(0, 4095)));
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (62) @(negedge CLK);
        chk("wrap_pc31", pc, 31);
        chk("wrap_ret31", retired, 31);
        repeat (2) @(negedge CLK);
        chk("wrap_pc0", pc, 0);
        chk("wrap_ret32", retired, 32);
        repeat (16) @(negedge CLK);
        chk("wrap_pc8", pc, 8);
        chk("wrap_ret40", retired, 40);
        chk("wrap_busy", busy, 1);
        chk("wrap_done", done, 0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;

        // prog_we and start together from IDLE: FETCH sees the new word
        gen_random(n);
        load_word(0, W_NOP);
        prog[0] = f_ld(5'($urandom_range(0, 31)), 15'($urandom_range(1, 32767)));
        run_prog(1'b1, -1, cyc);

        repeat (4) begin
            gen_random(n);
            run_prog(1'b0, -1, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
